array_masked_1r1w: RTL
======================

// Module: array_masked_1r1w
// PURPOSE
//  Single-clock, parametrised 1R1W masked-write array; successor to the fixed 256x16 dual-clock ext arrays.
//  Generalised width/depth/mask granularity. Registered, held read data.
//  Self-clearing init FSM after reset. Optional same-cycle write-to-read bypass.
//  Sits under Chisel-generated SRAM wrappers in frontend/cache metadata arrays.
// PARAMETERS
//  DATA_WIDTH  16   bits per entry
//  DEPTH       256  entries; need not be a power of two
//  ADDR_WIDTH  8    address bits; must be >= clog2(DEPTH)
//  MASK_WIDTH  8    write-mask bits; DATA_WIDTH % MASK_WIDTH == 0, granule G = DATA_WIDTH/MASK_WIDTH
// PORTS
//  clock      in   1           single clock, all logic posedge
//  reset      in   1           asynchronous, active-high
//  W0_en      in   1           write enable
//  W0_addr    in   ADDR_WIDTH  write address
//  W0_data    in   DATA_WIDTH  write data
//  W0_mask    in   MASK_WIDTH  bit k enables granule [k*G +: G]
//  R0_en      in   1           read enable
//  R0_addr    in   ADDR_WIDTH  read address
//  R0_data    out  DATA_WIDTH  registered read data
//  init_done  out  1           array cleared, ports live
// BEHAVIOUR
//  Reset (async assert) values: R0_data=0, init_done=0, FSM=INIT, init counter=0.
//  FSM INIT: one entry per cycle, ram[cnt] <= 0 (full width), cnt++.
//   - At cnt==DEPTH-1: write that entry, go READY.
//   - init_done=1 from the DEPTH-th edge after reset deassertion.
//  FSM READY: terminal until reset. Reset in any state (incl. mid-INIT) restarts INIT at cnt=0.
//  During INIT: W0_en and R0_en ignored. Writes dropped; R0_data holds 0.
//  Write (READY, W0_en=1): for each k with W0_mask[k]=1, granule k of ram[W0_addr] <= granule k of W0_data.
//   - Other granules unchanged.
//   - W0_mask=0 makes the write a no-op.
//  Read (READY, R0_en=1 at edge t): R0_data = ram[R0_addr] valid after edge t, i.e. 1-cycle latency.
//  Hold: R0_en=0 leaves R0_data unchanged indefinitely. Writes to the last-read address do not alter it.
//  Out of range (addr >= DEPTH): write dropped; read loads R0_data=0.
//  Simultaneous write+read, different addresses: fully independent.
//  Simultaneous write+read, same address: see CONFIGURATION.
//   - ram is always updated with the write regardless of the option.
// CONFIGURATION
//  ARRAY_BYPASS_EN defined: same-address same-cycle read returns the merged new value.
//   - Granule k comes from W0_data if W0_mask[k], else from the old ram content.
//   - Forward path is muxed before the R0_data register; latency stays 1 cycle.
//  ARRAY_BYPASS_EN undefined: read-before-write; R0_data returns the pre-write entry.
// TESTING
//  1 Init timing: DEPTH=256, release reset at edge 0.
//    -> init_done=0 through edge 255, =1 after edge 256.
//    -> read 0x7F -> R0_data=0x0000.
//  2 Basic/hold: write 0x10=0xABCD mask 0xFF; next cycle R0_en addr 0x10.
//    -> R0_data=0xABCD one edge later.
//    -> R0_en=0 for 3 cycles: R0_data stays 0xABCD, also while writing 0x10=0x0000.
//  3 Partial mask: from 0xABCD, write 0x10=0x1234 mask 0x0F -> read 0x10 = 0xAB34.
//  4 Collision: ram[0x20]=0x5555; same edge write 0xAAAA mask 0xF0 and read 0x20.
//    -> R0_data=0xAA55 with ARRAY_BYPASS_EN, 0x5555 without.
//    -> Next read 0x20 = 0xAA55 in both builds.
//  5 Reset mid-init: assert reset 100 cycles into INIT, release.
//    -> init_done rises 256 edges after the second release.
//    -> Write 0x01=0xFFFF issued during INIT is dropped; read 0x01 = 0x0000.
//  6 Range: DEPTH=200, ADDR_WIDTH=8; write addr 250=0xFFFF.
//    -> Read 250 = 0x0000.
//    -> Read 199 = 0x0000; entry 199 is unaffected.

Source files
------------

// File: rtl/array_masked_1r1w.sv
// Parametrised single-clock 1R1W masked-write array with self-clearing init.
// Define ARRAY_BYPASS_EN to forward same-address writes into the read register.
module array_masked_1r1w #(
  parameter int DATA_WIDTH = 16,
  parameter int DEPTH      = 256,
  parameter int ADDR_WIDTH = 8,
  parameter int MASK_WIDTH = 8
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  W0_en,
  input  logic [ADDR_WIDTH-1:0] W0_addr,
  input  logic [DATA_WIDTH-1:0] W0_data,
  input  logic [MASK_WIDTH-1:0] W0_mask,
  input  logic                  R0_en,
  input  logic [ADDR_WIDTH-1:0] R0_addr,
  output logic [DATA_WIDTH-1:0] R0_data,
  output logic                  init_done
);

  localparam int G = DATA_WIDTH / MASK_WIDTH;

  typedef enum logic {
    INIT,
    READY
  } state_t;

  state_t                  state_q, state_d;
  logic [ADDR_WIDTH-1:0]   cnt_q, cnt_d;
  logic [DATA_WIDTH-1:0]   rdata_q, rdata_d;
  logic [DATA_WIDTH-1:0]   ram [DEPTH];

  logic                    ready;
  logic                    w_ok;
  logic                    r_ok;
  logic [DATA_WIDTH-1:0]   wr_bits;
  logic                    mem_we;
  logic [ADDR_WIDTH-1:0]   mem_addr;
  logic [DATA_WIDTH-1:0]   mem_wdata;
  logic [DATA_WIDTH-1:0]   mem_bits;

  assign ready = (state_q == READY);
  assign w_ok  = ready && W0_en && (32'(W0_addr) < 32'(DEPTH));
  assign r_ok  = (32'(R0_addr) < 32'(DEPTH));

  // Expand granule mask into a per-bit enable
  always_comb begin
    wr_bits = '0;
    for (int k = 0; k < MASK_WIDTH; k++) begin
      wr_bits[k*G +: G] = {G{W0_mask[k]}};
    end
  end

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    mem_we    = 1'b0;
    mem_addr  = W0_addr;
    mem_wdata = W0_data;
    mem_bits  = wr_bits;
    case (state_q)
      INIT: begin
        mem_we    = 1'b1;
        mem_addr  = cnt_q;
        mem_wdata = '0;
        mem_bits  = '1;
        cnt_d     = cnt_q + 1'b1;
        if (32'(cnt_q) == 32'(DEPTH - 1)) begin
          state_d = READY;
          cnt_d   = '0;
        end
      end
      READY: begin
        mem_we = w_ok;
      end
      default: state_d = INIT;
    endcase
  end

  always_comb begin
    rdata_d = rdata_q;
    if (ready && R0_en) begin
      if (r_ok) begin
        rdata_d = ram[R0_addr];
`ifdef ARRAY_BYPASS_EN
        if (w_ok && (W0_addr == R0_addr)) begin
          rdata_d = (rdata_d & ~wr_bits) | (W0_data & wr_bits);
        end
`endif
      end else begin
        rdata_d = '0;
      end
    end
  end

  always_ff @(posedge clock) begin
    if (mem_we) begin
      ram[mem_addr] <= (ram[mem_addr] & ~mem_bits) | (mem_wdata & mem_bits);
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q <= INIT;
      cnt_q   <= '0;
      rdata_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      rdata_q <= rdata_d;
    end
  end

  assign R0_data   = rdata_q;
  assign init_done = ready;

endmodule
